uart_tx_fifo_drain: RTL

//   UART serial transmitter that drains the TX byte FIFO (reader side of the fifo block).

---
 rtl/uart_tx_fifo_drain_if.sv | 23 ++
 rtl/uart_tx_fifo_drain.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_drain_if.sv
// Handshake bundle between the TX FIFO read side, the UART transmitter and the tx pin.
// The master side feeds enable/FIFO status; the slave side is the transmitter.
interface uart_tx_fifo_drain_if #(
  parameter int unsigned D_W = 8
);
  logic           tx_en;
  logic           fifo_empty;
  logic [D_W-1:0] fifo_data;
  logic           fifo_rd_en;
  logic           tx;
  logic           busy;
  logic           tx_done;

  modport master (
    output tx_en, fifo_empty, fifo_data,
    input  fifo_rd_en, tx, busy, tx_done
  );

  modport slave (
    input  tx_en, fifo_empty, fifo_data,
    output fifo_rd_en, tx, busy, tx_done
  );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pops one FIFO word per frame and serialises it LSB first,
// with optional parity and one or two stop bits. All outputs are registered.
module uart_tx_fifo_drain #(
  parameter int unsigned D_W          = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input logic                clk,
  input logic                rst,
  uart_tx_fifo_drain_if.slave bus
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = (D_W > 1) ? $clog2(D_W) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] DoneAt   = CntW'(CLKS_PER_BIT - 2);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(D_W - 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StLatch, StStart, StData, StParity, StStop
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] baud_q;
  logic [IdxW-1:0] idx_q;
  logic            stop_q;
  logic [D_W-1:0]  shreg_q;
  logic            parity_q;
  logic            tx_q;
  logic            rd_q;
  logic            busy_q;
  logic            done_q;

  logic bit_end;
  logic last_stop;

  always_comb begin
    bit_end   = (baud_q == BaudLast);
    last_stop = (stop_q == 1'(STOP_BITS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      shreg_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (bus.tx_en && !bus.fifo_empty) begin
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StFetch;
          end
        end
        // FIFO registers the read at the end of this cycle; data is usable in LATCH.
        StFetch: state_q <= StLatch;
        StLatch: begin
          shreg_q  <= bus.fifo_data;
          parity_q <= (^bus.fifo_data) ^ 1'(PARITY_ODD);
          tx_q     <= 1'b0;
          baud_q   <= '0;
          state_q  <= StStart;
        end
        StStart: begin
          if (bit_end) begin
            baud_q  <= '0;
            tx_q    <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
            idx_q   <= '0;
            state_q <= StData;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StData: begin
          if (bit_end) begin
            baud_q <= '0;
            if (idx_q == IdxLast) begin
              if (PARITY_EN != 0) begin
                tx_q    <= parity_q;
                state_q <= StParity;
              end else begin
                tx_q    <= 1'b1;
                stop_q  <= 1'b0;
                state_q <= StStop;
              end
            end else begin
              tx_q    <= shreg_q[0];
              shreg_q <= shreg_q >> 1;
              idx_q   <= idx_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StParity: begin
          if (bit_end) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            stop_q  <= 1'b0;
            state_q <= StStop;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StStop: begin
          if (!bit_end) begin
            baud_q <= baud_q + 1'b1;
            // Registered pulse must already be high during the final stop cycle.
            if (last_stop && (baud_q == DoneAt)) done_q <= 1'b1;
          end else begin
            baud_q <= '0;
            if (last_stop) begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              stop_q <= 1'b1;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.fifo_rd_en = rd_q;
  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.tx_done    = done_q;

endmodule
